// File: rtl/led_pkg.sv
// Shared types and constants for the LED panel scan path.
// No logic and no latency; imported by scan_ctl and sclk_gen.
// No flow control; the widths here bound the programmable timing parameters.
package led_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_LATCH   = 3'd2,
    S_SETTLE  = 3'd3,
    S_DISPLAY = 3'd4
  } scan_state_t;

  localparam int NROWS_SCAN = 8;   // rows per frame on a 1/8-scan panel
  localparam int PANEL_COLS = 32;  // columns shifted per row
  localparam int TCNT_W     = 16;  // dwell counter width for SETTLE/DISPLAY

endpackage

// File: rtl/sclk_gen.sv
// Column address walker and panel shift clock for one row of pixels.
// col changes one cycle after a completed sclk period; sclk decodes from the phase counter.
// No backpressure; counts only while en is high and parks at zero otherwise.
module sclk_gen
  import led_pkg::*;
#(
  parameter int NCOLS     = PANEL_COLS,
  parameter int SCLK_HALF = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic                     sclk,
  output logic [$clog2(NCOLS)-1:0] col,
  output logic                     last_col_tick
);

  localparam int COL_W = $clog2(NCOLS);
  localparam int PH_W  = $clog2(2 * SCLK_HALF);

  logic [PH_W-1:0] ph;
  logic            last_ph;
  logic            last_col;

  assign last_ph  = (ph == PH_W'(2 * SCLK_HALF - 1));
  assign last_col = (col == COL_W'(NCOLS - 1));

  // Step the sclk phase every cycle while shifting; advance the column once per full sclk period.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      ph  <= '0;
      col <= '0;
    end else if (last_ph) begin
      ph  <= '0;
      col <= last_col ? '0 : col + COL_W'(1);
    end else begin
      ph <= ph + PH_W'(1);
    end
  end

  // Low half first so the RAM has SCLK_HALF cycles to present data before the rising edge.
  assign sclk          = en && (ph >= PH_W'(SCLK_HALF));
  assign last_col_tick = en && last_ph && last_col;

endmodule

// File: rtl/scan_ctl.sv
// Panel scan controller: shift a row, latch it, settle row address, then light it for ON_CYC cycles.
// Row period NCOLS*2*SCLK_HALF + 1 + SETTLE_CYC + ON_CYC cycles; all outputs are registered-state decodes.
// No backpressure; enb is sampled only in IDLE and on the last DISPLAY cycle, so rows always complete.
module scan_ctl
  import led_pkg::*;
#(
  parameter int NCOLS      = PANEL_COLS,
  parameter int SCLK_HALF  = 1,
  parameter int SETTLE_CYC = 2,
  parameter int ON_CYC     = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enb,
  input  logic                     row_eq_7,
  output logic                     rowct_clr,
  output logic                     rowct_enb,
  output logic [$clog2(NCOLS)-1:0] col,
  output logic                     sclk,
  output logic                     lat,
  output logic                     oe_n,
  output logic                     busy,
  output logic                     frame_done
);

  scan_state_t       state, state_nxt;
  logic [TCNT_W-1:0] tcnt;
  logic              last_row;
  logic              shift_en;
  logic              last_col_tick;
  logic              settle_done;
  logic              on_done;
  logic              dwell;

  assign shift_en    = (state == S_SHIFT);
  assign dwell       = (state == S_SETTLE) || (state == S_DISPLAY);
  assign settle_done = (tcnt == TCNT_W'(SETTLE_CYC - 1));
  assign on_done     = (tcnt == TCNT_W'(ON_CYC - 1));

  sclk_gen #(
    .NCOLS     (NCOLS),
    .SCLK_HALF (SCLK_HALF)
  ) u_sclk_gen (
    .clk           (clk),
    .rst           (rst),
    .en            (shift_en),
    .sclk          (sclk),
    .col           (col),
    .last_col_tick (last_col_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Dwell counter for SETTLE and DISPLAY; restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst || !dwell || (state_nxt != state)) tcnt <= '0;
    else                                       tcnt <= tcnt + TCNT_W'(1);
  end

  // Remember whether the row just shifted was row 7, sampled before rowctr advances.
  always_ff @(posedge clk) begin
    if (rst)                 last_row <= 1'b0;
    else if (state == S_LATCH) last_row <= row_eq_7;
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_nxt  = state;
    rowct_clr  = 1'b0;
    rowct_enb  = 1'b0;
    lat        = 1'b0;
    oe_n       = 1'b1;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        rowct_clr = 1'b1;
        busy      = 1'b0;
        if (enb) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_col_tick) state_nxt = S_LATCH;
      end
      S_LATCH: begin
        lat       = 1'b1;
        rowct_enb = 1'b1;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_done) state_nxt = S_DISPLAY;
      end
      S_DISPLAY: begin
        oe_n = 1'b0;
        if (on_done) begin
          frame_done = last_row;
          state_nxt  = enb ? S_SHIFT : S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_ctl.sv
// Bench for scan_ctl: two instances (default timing and a short-timing variant) each with a rowctr model.
// A row-position reference model predicts every output each cycle; directed checks pin the key timings.
// Stimulus ends with randomized enb toggles and reset pulses.
module tb_scan_ctl;

  localparam int NC = 32;
  localparam int HA = 1, SA = 2, OA = 256;
  localparam int HB = 2, SB = 1, OB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enb = 1'b0;

  always #5 clk = ~clk;

  logic       a_clr, a_enb, a_sclk, a_lat, a_oe_n, a_busy, a_fd, a_r7;
  logic       b_clr, b_enb, b_sclk, b_lat, b_oe_n, b_busy, b_fd, b_r7;
  logic [4:0] a_col, b_col;
  logic [2:0] a_row = 3'd0;
  logic [2:0] b_row = 3'd0;

  scan_ctl u_dut_a (
    .clk(clk), .rst(rst), .enb(enb), .row_eq_7(a_r7),
    .rowct_clr(a_clr), .rowct_enb(a_enb), .col(a_col), .sclk(a_sclk),
    .lat(a_lat), .oe_n(a_oe_n), .busy(a_busy), .frame_done(a_fd)
  );

  scan_ctl #(.SCLK_HALF(HB), .SETTLE_CYC(SB), .ON_CYC(OB)) u_dut_b (
    .clk(clk), .rst(rst), .enb(enb), .row_eq_7(b_r7),
    .rowct_clr(b_clr), .rowct_enb(b_enb), .col(b_col), .sclk(b_sclk),
    .lat(b_lat), .oe_n(b_oe_n), .busy(b_busy), .frame_done(b_fd)
  );

  // Downstream row counters: clear to 0, advance on rowct_enb, natural 3-bit wrap.
  always @(posedge clk) begin
    if (a_clr) a_row <= 3'd0; else if (a_enb) a_row <= a_row + 3'd1;
    if (b_clr) b_row <= 3'd0; else if (b_enb) b_row <= b_row + 3'd1;
  end
  assign a_r7 = (a_row == 3'd7);
  assign b_r7 = (b_row == 3'd7);

  logic [11:0] obs_a, obs_b;
  assign obs_a = {a_clr, a_enb, a_col, a_sclk, a_lat, a_oe_n, a_busy, a_fd};
  assign obs_b = {b_clr, b_enb, b_col, b_sclk, b_lat, b_oe_n, b_busy, b_fd};

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: running flag, position within the row period, row index within the frame.
  int m_run[2] = '{0, 0};
  int m_pos[2] = '{0, 0};
  int m_row[2] = '{0, 0};

  function automatic int half(input int d);  return (d == 0) ? HA : HB; endfunction
  function automatic int settle(input int d); return (d == 0) ? SA : SB; endfunction
  function automatic int ontime(input int d); return (d == 0) ? OA : OB; endfunction
  function automatic int shlen(input int d);  return NC * 2 * half(d); endfunction
  function automatic int period(input int d); return shlen(d) + 1 + settle(d) + ontime(d); endfunction

  function automatic logic [11:0] exp_vec(input int d);
    int   h, pos;
    logic [4:0] c;
    logic sk, lt, oe, fd;
    h = half(d); pos = m_pos[d];
    if (m_run[d] == 0) return 12'b1_0_00000_0_0_1_0_0;
    c = 5'd0; sk = 1'b0; lt = 1'b0; oe = 1'b1; fd = 1'b0;
    if (pos < shlen(d)) begin
      c  = 5'(pos / (2 * h));
      sk = (pos % (2 * h)) >= h;
    end else if (pos == shlen(d)) begin
      lt = 1'b1;
    end else if (pos > shlen(d) + settle(d)) begin
      oe = 1'b0;
      fd = (pos == period(d) - 1) && (m_row[d] == 7);
    end
    return {1'b0, lt, c, sk, lt, oe, 1'b1, fd};
  endfunction

  task automatic step(input int d);
    if (rst) m_run[d] = 0;
    else if (m_run[d] == 0) begin
      if (enb) begin m_run[d] = 1; m_pos[d] = 0; m_row[d] = 0; end
    end else if (m_pos[d] == period(d) - 1) begin
      if (enb) begin m_pos[d] = 0; m_row[d] = (m_row[d] + 1) % 8; end
      else m_run[d] = 0;
    end else m_pos[d]++;
  endtask

  // One clock: compare both instances against the model mid-cycle, then advance the model.
  task automatic tick();
    @(negedge clk);
    chk("vec_a", 32'(obs_a), 32'(exp_vec(0)));
    chk("vec_b", 32'(obs_b), 32'(exp_vec(1)));
    @(posedge clk);
    step(0);
    step(1);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int na_rise, nb_rise, na_en, na_fd;
    logic pa, pb;

    // Reset held 3 cycles, then idle with enb low.
    rst = 1'b1; enb = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (100) tick();
    chk("rst_oe_n", a_oe_n, 1);
    chk("rst_clr", a_clr, 1);
    chk("rst_busy", a_busy, 0);

    // First row timing and a full frame, enb high from cycle 0.
    enb = 1'b1; na_rise = 0; nb_rise = 0; na_en = 0; na_fd = 0; pa = 1'b0; pb = 1'b0;
    for (int c = 0; c <= 2590; c++) begin
      if (c >= 1 && c <= 64 && a_sclk && !pa) na_rise++;
      if (c >= 1 && c <= 128 && b_sclk && !pb) nb_rise++;
      pa = a_sclk; pb = b_sclk;
      if (c <= 2584 && a_enb) begin
        na_en++;
        if (na_en == 8) chk("r7_8th_latch", a_r7, 1);
      end
      if (c <= 2585 && a_fd) na_fd++;
      case (c)
        64:   chk("lat_64", a_lat, 0);
        65:   begin chk("lat_65", a_lat, 1); chk("rowenb_65", a_enb, 1); chk("rise_a", na_rise, 32); end
        66:   begin chk("lat_66", a_lat, 0); chk("oe_66", a_oe_n, 1); end
        67:   chk("oe_67", a_oe_n, 1);
        68:   chk("oe_68", a_oe_n, 0);
        129:  chk("rise_b", nb_rise, 32);
        323:  chk("oe_323", a_oe_n, 0);
        324:  chk("shift2_324", {a_oe_n, a_sclk, a_col}, {2'b10, 5'd0});
        325:  chk("sclk_325", a_sclk, 1);
        1071: chk("fd_b_1071", b_fd, 0);
        1072: chk("fd_b_1072", b_fd, 1);
        1073: chk("fd_b_1073", b_fd, 0);
        2583: chk("fd_a_2583", a_fd, 0);
        2584: begin chk("fd_a_2584", a_fd, 1); chk("rowenb_cnt", na_en, 8); end
        2585: begin chk("fd_cnt", na_fd, 1); chk("f2_row", a_row, 0); chk("f2_clr", a_clr, 0); end
        default: ;
      endcase
      tick();
    end
    rst = 1'b1; enb = 1'b0; tick();
    rst = 1'b0; tick();

    // enb dropped mid-SHIFT: the row still completes.
    enb = 1'b1;
    for (int c = 0; c <= 330; c++) begin
      if (c == 30) enb = 1'b0;
      case (c)
        323: begin chk("drop_busy_323", a_busy, 1); chk("drop_oe_323", a_oe_n, 0); end
        324: begin chk("drop_busy_324", a_busy, 0); chk("drop_clr_324", a_clr, 1); chk("drop_oe_324", a_oe_n, 1); end
        330: chk("drop_idle_330", {a_clr, a_oe_n, a_busy}, 3'b110);
        default: ;
      endcase
      tick();
    end

    // Reset mid-DISPLAY.
    enb = 1'b1;
    for (int c = 0; c <= 205; c++) begin
      if (c == 200) begin rst = 1'b1; enb = 1'b0; end
      if (c == 201) rst = 1'b0;
      case (c)
        199: chk("mid_disp_oe", a_oe_n, 0);
        201: chk("rst_disp_idle", {a_busy, a_oe_n, a_lat, a_fd, a_clr}, 5'b01001);
        default: ;
      endcase
      tick();
    end

    // Randomized enb toggling with occasional reset pulses.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 199) == 0) enb = ~enb;
      rst = ($urandom_range(0, 2999) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
